pe_dot_feeder: RTL
==================

Name: pe_dot_feeder

Overview:
Upstream sequencer for the FP32 MAC PE. It buffers incoming operand pairs in a small FIFO and issues them one at a time to the PE as single-cycle in_valid pulses. It feeds each returned psum back as the next psum_in, and emits the finished dot product when the element tagged last completes. The PE is multi-cycle and has no ready signal, so this block guarantees a new operation is issued only after the previous result has returned.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 4096, cycles allowed in WAIT before timeout flag sets

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  FIFO can accept (= !full)
s_a  in  32  FP32 operand a
s_b  in  32  FP32 operand b
s_last  in  1  final element of current dot product
pe_in_valid  out  1  1-cycle issue pulse to PE
pe_a_bits  out  32  to PE a_bits
pe_b_bits  out  32  to PE b_bits
pe_psum_in  out  32  to PE psum_in (running accumulator)
pe_out_valid  in  1  PE result pulse
pe_psum_out  in  32  PE result
m_valid  out  1  dot-product result valid
m_ready  in  1  downstream accepts
m_data  out  32  FP32 dot-product result
m_len  out  16  element count of the emitted dot product
err  out  2  sticky; [0] PE timeout, [1] pe_out_valid outside WAIT

Behaviour:
- Reset values: all outputs 0, FIFO empty (s_ready=1 the cycle after reset releases), acc=0, elem count 0, state IDLE.
- FIFO write on s_valid&&s_ready. Push while full is rejected because s_ready=0; no simultaneous pop credit is taken.
- Each FIFO entry holds {a, b, last}. Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- FSM states: IDLE, WAIT, OUT.
- IDLE, FIFO non-empty:
  - Registers pe_in_valid<=1.
  - pe_a/pe_b <= head entry; pe_psum_in <= acc; last_r <= head.last.
  - Pops the FIFO, cnt++, clears the timer, goes to WAIT.
- IDLE, FIFO empty: holds. acc stays preserved across gaps within a vector.
- Latency: an entry pushed at edge N into an empty FIFO while IDLE gives pe_in_valid high during cycle N+1 to N+2.
- WAIT:
  - pe_in_valid<=0, so the pulse is exactly 1 cycle. pe_a/pe_b/pe_psum_in hold until the next issue.
  - Timer increments each cycle; at timer==TIMEOUT_CYC-1, err[0]<=1. State does not change, so a late result is still accepted.
  - On pe_out_valid: acc<=pe_psum_out.
    - If last_r: m_data<=pe_psum_out, m_len<=cnt, m_valid<=1, go to OUT.
    - Else: go to IDLE.
- OUT:
  - m_valid and m_data held stable until m_ready.
  - On m_valid&&m_ready: m_valid<=0, acc<=0, cnt<=0, go to IDLE.
  - The FIFO keeps accepting while in OUT; no issue occurs while in OUT.
- pe_out_valid seen in IDLE or OUT: ignored for data, err[1]<=1.
- Issue and FIFO push may happen in the same cycle. count is updated with both the +1 and the -1.
- cnt saturates at 16'hFFFF.
- err bits clear only on rst.
- rst mid-operation: everything returns to reset values immediately, FIFO contents discarded. The PE shares rst, so it also aborts.

Test Plan:
- Single element (a=3F800000, b=3F800000, last=1) -> one pe_in_valid pulse with pe_psum_in=00000000; m_valid with m_data=3F800000, m_len=1.
- Two elements (40000000×40400000, then 40800000×3F000000 last) -> second issue has pe_psum_in=40C00000; m_data=41000000, m_len=2; exactly 2 pulses, each 1 cycle wide, never while the PE is busy.
- Back-to-back vectors with m_ready held low 20 cycles -> m_valid/m_data stable throughout; FIFO fills to DEPTH=4 and s_ready=0; after m_ready=1 the next vector starts with pe_psum_in=00000000.
- Stub PE that never responds, TIMEOUT_CYC=16 -> err[0] rises 16 cycles after the issue pulse; a late pe_out_valid afterward completes normally.
- Spurious pe_out_valid pulse while IDLE -> err[1]=1; acc and outputs unchanged.
- rst asserted while in WAIT with 3 entries queued -> next cycle all outputs 0, s_ready=1, no further pe_in_valid until new pushes arrive.

Source files
------------

// File: rtl/pe_dot_feeder.sv
// pe_dot_feeder: upstream sequencer for a multi-cycle FP32 MAC PE.
// Buffers {a, b, last} operand pairs in a small FIFO. It issues them one at a time as
// single-cycle pe_in_valid_o pulses. Each returned psum is fed back as the next psum_in.
// The finished dot product is emitted when the element tagged last completes.
// The PE has no ready signal, so a new issue only happens once the previous result is back.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   s_*                   operand stream in (valid/ready, a, b, last)
//   pe_in_valid_o, pe_*   issue pulse and operands to the PE
//   pe_out_valid_i,
//   pe_psum_out_i         PE result pulse and data
//   m_*                   dot-product result out (valid/ready, data, element count)
//   err_o                 sticky: [0] PE timeout, [1] PE result outside WAIT
module pe_dot_feeder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_a_i,
  input  logic [31:0] s_b_i,
  input  logic        s_last_i,
  output logic        pe_in_valid_o,
  output logic [31:0] pe_a_bits_o,
  output logic [31:0] pe_b_bits_o,
  output logic [31:0] pe_psum_in_o,
  input  logic        pe_out_valid_i,
  input  logic [31:0] pe_psum_out_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_data_o,
  output logic [15:0] m_len_o,
  output logic [1:0]  err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StWait, StOut} state_e;

  // FIFO storage: {a, b, last}
  logic [64:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, push, pop;
  logic [64:0]     head;

  state_e          state_q, state_d;
  logic            pe_in_valid_q, pe_in_valid_d;
  logic [31:0]     pe_a_q, pe_a_d, pe_b_q, pe_b_d, pe_psum_q, pe_psum_d;
  logic            last_q, last_d;
  logic [31:0]     acc_q, acc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            m_valid_q, m_valid_d;
  logic [31:0]     m_data_q, m_data_d;
  logic [15:0]     m_len_q, m_len_d;
  logic [1:0]      err_q, err_d;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign s_ready_o = ~full;
  assign push      = s_valid_i & ~full;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    pe_in_valid_d = 1'b0;
    pe_a_d        = pe_a_q;
    pe_b_d        = pe_b_q;
    pe_psum_d     = pe_psum_q;
    last_d        = last_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_len_d       = m_len_q;
    err_d         = err_q;
    pop           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop           = 1'b1;
          pe_in_valid_d = 1'b1;
          pe_a_d        = head[64:33];
          pe_b_d        = head[32:1];
          last_d        = head[0];
          pe_psum_d     = acc_q;
          cnt_d         = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          timer_d       = '0;
          state_d       = StWait;
        end
      end
      StWait: begin
        // Timer saturates; the flag is sticky so re-asserting it is harmless.
        if (timer_q != TmrLast) timer_d = timer_q + 1'b1;
        if (timer_q == TmrLast) err_d[0] = 1'b1;
        if (pe_out_valid_i) begin
          acc_d = pe_psum_out_i;
          if (last_q) begin
            m_data_d  = pe_psum_out_i;
            m_len_d   = cnt_q;
            m_valid_d = 1'b1;
            state_d   = StOut;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOut: begin
        if (m_valid_q && m_ready_i) begin
          m_valid_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A result pulse is only legal while a PE operation is outstanding.
    if (pe_out_valid_i && (state_q != StWait)) err_d[1] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s_a_i, s_b_i, s_last_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      pe_in_valid_q <= 1'b0;
      pe_a_q        <= '0;
      pe_b_q        <= '0;
      pe_psum_q     <= '0;
      last_q        <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_len_q       <= '0;
      err_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      pe_in_valid_q <= pe_in_valid_d;
      pe_a_q        <= pe_a_d;
      pe_b_q        <= pe_b_d;
      pe_psum_q     <= pe_psum_d;
      last_q        <= last_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_len_q       <= m_len_d;
      err_q         <= err_d;
    end
  end

  assign pe_in_valid_o = pe_in_valid_q;
  assign pe_a_bits_o   = pe_a_q;
  assign pe_b_bits_o   = pe_b_q;
  assign pe_psum_in_o  = pe_psum_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_len_o       = m_len_q;
  assign err_o         = err_q;

endmodule
